ram_sync_clr: RTL and testbench
===============================

// Module: ram_sync_clr
// PURPOSE
//  Parametrised single-port synchronous RAM for the SAP datapath; successor to
//  the fixed 8x256 RAM. Adds a read enable, 1-cycle registered read with valid
//  flag, selectable read-during-write mode, and a hardware clear sequencer.
//  The clear sequencer sweeps every word to CLR_VAL after reset or on request,
//  so program/data memory starts from a known state without testbench preload.
// PARAMETERS
//  DATA_W    8             word width in bits
//  ADDR_W    8             address width in bits
//  DEPTH     1<<ADDR_W     number of words; 1 <= DEPTH <= 2**ADDR_W
//  RDW_MODE  0             read-during-write: 0 = old data, 1 = new (din)
//  CLR_VAL   '0            value written to every word by the clear sweep
// PORTS
//  clk         in   1       clock; all logic on posedge
//  rst_n       in   1       synchronous active-low reset
//  addr        in   ADDR_W  word address for read/write
//  din         in   DATA_W  write data
//  we          in   1       write enable, sampled at posedge
//  re          in   1       read enable, sampled at posedge
//  clr_req     in   1       request a full clear sweep (pulse, IDLE only)
//  dout        out  DATA_W  registered read data; holds between reads
//  dout_valid  out  1       high for one cycle after an accepted read
//  busy        out  1       high while the clear sweep runs; ports ignored
// BEHAVIOUR
//  - Reset (rst_n low at posedge): state<=CLEAR, clr_cnt<=0, dout<=0,
//    dout_valid<=0. Array contents are not reset directly; the sweep clears them.
//  - busy = (state==CLEAR), combinational from state; it reads 1 during reset.
//  - CLEAR: each posedge writes CLR_VAL to mem[clr_cnt], then clr_cnt++.
//    At the edge that writes clr_cnt==DEPTH-1, state<=IDLE.
//    busy is high for exactly DEPTH cycles after rst_n is released.
//  - CLEAR ignores we/re/clr_req. dout holds its value and dout_valid=0.
//  - IDLE, clr_req=1: state<=CLEAR, clr_cnt<=0. A we/re in the same cycle
//    is dropped and dout_valid<=0, so clear wins over a simultaneous access.
//  - IDLE write: we=1 and addr<DEPTH gives mem[addr]<=din at the posedge.
//  - IDLE read: re=1 gives dout<=mem[addr] and dout_valid<=1 at the posedge,
//    so data is visible 1 cycle after re is sampled. re=0 gives dout_valid<=0
//    and dout holds.
//  - we=re=1 on the same addr: RDW_MODE=0 gives dout=previous content;
//    RDW_MODE=1 gives dout=din. The write always completes.
//  - Out-of-range addr (addr>=DEPTH, only possible when DEPTH<2**ADDR_W):
//    the write is dropped; a read returns dout<=CLR_VAL with dout_valid<=1.
//  - Reset mid-sweep restarts the sweep at address 0 (full DEPTH cycles again).
//  - Back-to-back reads/writes are accepted every cycle (throughput 1/cycle).
//  - FSM states: CLEAR, IDLE. Transitions: reset->CLEAR, CLEAR(last)->IDLE,
//    IDLE(clr_req)->CLEAR.
// TESTING
//  1. Defaults, reset 2 cycles then release -> busy=1 for exactly 256 cycles,
//     then 0; dout=0 and dout_valid=0 throughout.
//  2. After clear: write addr i=0..9 with din=i+100, then read 0..9 ->
//     dout=i+100 one cycle after each re; dout_valid pulses per read; addr 10 reads 0.
//  3. RDW_MODE=0: mem[5]=105, then we=re=1 at addr 5, din=55 -> dout=105, next
//     read=55. Repeat with RDW_MODE=1 -> dout=55.
//  4. Write 0xAA to addrs 0..255, pulse clr_req with we=1 (addr 3, din 0x11) ->
//     busy 256 cycles, write dropped; all reads return CLR_VAL (0).
//  5. Reset asserted at clr_cnt=100, released 1 cycle later -> busy stays high
//     256 more cycles; addr 200 reads 0 afterwards.
//  6. DEPTH=200: write addr 250 din=0x5A, read 250 -> dout=CLR_VAL, dout_valid=1;
//     addr 199 write/read round-trips.

Source files
------------

// File: rtl/ram_sync_clr.sv
// ram_sync_clr: single-port synchronous RAM with a registered, enabled read,
// selectable read-during-write behaviour and a clear sequencer that sweeps
// every word to CLR_VAL after reset or on request.
module ram_sync_clr #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 1 << ADDR_W,
    parameter int                RDW_MODE = 0,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              we,
    input  logic              re,
    input  logic              clr_req,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_CLEAR = 1'b1;

    // Index width of the physical array; a 1-word array still needs a 1-bit index.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;

    logic              addr_ok;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] rd_data;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [DATA_W-1:0] mem_wdata;

    // Address decode and array read; out-of-range words read back as CLR_VAL.
    always_comb begin
        addr_ok = ({1'b0, addr} < DEPTH_EXT);
        acc_idx = addr[IDX_W-1:0];
        rd_data = CLR_VAL;
        if (addr_ok) begin
            rd_data = mem[acc_idx];
        end
    end

    // Next-state logic: clear sweep, clear request, and normal access.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        mem_we       = 1'b0;
        mem_widx     = acc_idx;
        mem_wdata    = din;
        case (state_q)
            ST_CLEAR: begin
                // Port inputs are ignored; one word is cleared per cycle.
                mem_we    = 1'b1;
                mem_widx  = clr_cnt_q[IDX_W-1:0];
                mem_wdata = CLR_VAL;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                if (clr_req) begin
                    // Clear takes priority; a same-cycle access is dropped.
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else begin
                    mem_we = we && addr_ok;
                    if (re) begin
                        dout_valid_d = 1'b1;
                        // Array read sees pre-write contents, giving old-data
                        // behaviour unless forwarding of din is selected.
                        if ((RDW_MODE != 0) && we && addr_ok) begin
                            dout_d = din;
                        end else begin
                            dout_d = rd_data;
                        end
                    end
                end
            end
        endcase
    end

    // Control and output registers with synchronous reset into the sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Storage array; no reset, contents are initialised by the sweep.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_sync_clr.sv
// Directed bench for ram_sync_clr: default instance (a), new-data
// read-during-write instance (b), and a 200-word instance with a non-zero
// clear value (c).
module tb_ram_sync_clr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] a_addr, a_din, a_dout;
    logic       a_we, a_re, a_clr, a_dv, a_busy;
    logic [7:0] b_addr, b_din, b_dout;
    logic       b_we, b_re, b_clr, b_dv, b_busy;
    logic [7:0] c_addr, c_din, c_dout;
    logic       c_we, c_re, c_clr, c_dv, c_busy;

    int tests = 0;
    int fails = 0;

    ram_sync_clr u_a (
        .clk(clk), .rst_n(rst_n), .addr(a_addr), .din(a_din), .we(a_we),
        .re(a_re), .clr_req(a_clr), .dout(a_dout), .dout_valid(a_dv),
        .busy(a_busy)
    );

    ram_sync_clr #(.RDW_MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .addr(b_addr), .din(b_din), .we(b_we),
        .re(b_re), .clr_req(b_clr), .dout(b_dout), .dout_valid(b_dv),
        .busy(b_busy)
    );

    ram_sync_clr #(.DEPTH(200), .CLR_VAL(8'h3C)) u_c (
        .clk(clk), .rst_n(rst_n), .addr(c_addr), .din(c_din), .we(c_we),
        .re(c_re), .clr_req(c_clr), .dout(c_dout), .dout_valid(c_dv),
        .busy(c_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic a_wr(input logic [7:0] ad, input logic [7:0] d);
        a_addr = ad; a_din = d; a_we = 1'b1;
        tick();
        a_we = 1'b0;
    endtask

    task automatic a_rd(input string tag, input logic [7:0] ad, input logic [7:0] exp);
        a_addr = ad; a_re = 1'b1;
        tick();
        a_re = 1'b0;
        chk(tag, 32'(a_dout), 32'(exp));
        chk({tag, "_v"}, 32'(a_dv), 32'd1);
    endtask

    task automatic b_wr(input logic [7:0] ad, input logic [7:0] d);
        b_addr = ad; b_din = d; b_we = 1'b1;
        tick();
        b_we = 1'b0;
    endtask

    task automatic b_rd(input string tag, input logic [7:0] ad, input logic [7:0] exp);
        b_addr = ad; b_re = 1'b1;
        tick();
        b_re = 1'b0;
        chk(tag, 32'(b_dout), 32'(exp));
        chk({tag, "_v"}, 32'(b_dv), 32'd1);
    endtask

    task automatic c_wr(input logic [7:0] ad, input logic [7:0] d);
        c_addr = ad; c_din = d; c_we = 1'b1;
        tick();
        c_we = 1'b0;
    endtask

    task automatic c_rd(input string tag, input logic [7:0] ad, input logic [7:0] exp);
        c_addr = ad; c_re = 1'b1;
        tick();
        c_re = 1'b0;
        chk(tag, 32'(c_dout), 32'(exp));
        chk({tag, "_v"}, 32'(c_dv), 32'd1);
    endtask

    // Count cycles until instance a leaves the sweep, bounded.
    task automatic a_busy_len(output int n);
        n = 0;
        while (a_busy === 1'b1 && n < 600) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int na, nb, nc, bad, n;
        a_addr = '0; a_din = '0; a_we = 0; a_re = 0; a_clr = 0;
        b_addr = '0; b_din = '0; b_we = 0; b_re = 0; b_clr = 0;
        c_addr = '0; c_din = '0; c_we = 0; c_re = 0; c_clr = 0;

        // 1. reset, then sweep length on all instances
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(a_busy), 32'd1);
        chk("rst_dout", 32'(a_dout), 32'd0);
        chk("rst_dv", 32'(a_dv), 32'd0);
        rst_n = 1'b1;
        na = -1; nb = -1; nc = -1; bad = 0;
        for (int i = 0; i < 400; i++) begin
            if (a_busy !== 1'b1 && na < 0) na = i;
            if (b_busy !== 1'b1 && nb < 0) nb = i;
            if (c_busy !== 1'b1 && nc < 0) nc = i;
            if (a_busy === 1'b1 && (a_dout !== 8'd0 || a_dv !== 1'b0)) bad++;
            tick();
        end
        chk("sweep_len_a", 32'(na), 32'd256);
        chk("sweep_len_b", 32'(nb), 32'd256);
        chk("sweep_len_c", 32'(nc), 32'd200);
        chk("sweep_out_quiet", 32'(bad), 32'd0);

        // 2. write/read round trip, then idle holds dout
        for (int i = 0; i < 10; i++) a_wr(8'(i), 8'(i + 100));
        for (int i = 0; i < 10; i++) a_rd($sformatf("rd%0d", i), 8'(i), 8'(i + 100));
        a_rd("rd10_clear", 8'd10, 8'd0);
        tick();
        chk("idle_dv_low", 32'(a_dv), 32'd0);
        chk("idle_dout_hold", 32'(a_dout), 32'd0);

        // 3. read-during-write, old data then new data
        a_addr = 8'd5; a_din = 8'd55; a_we = 1'b1; a_re = 1'b1;
        tick();
        a_we = 1'b0; a_re = 1'b0;
        chk("rdw_old", 32'(a_dout), 32'd105);
        a_rd("rdw_old_after", 8'd5, 8'd55);
        b_wr(8'd5, 8'd105);
        b_addr = 8'd5; b_din = 8'd55; b_we = 1'b1; b_re = 1'b1;
        tick();
        b_we = 1'b0; b_re = 1'b0;
        chk("rdw_new", 32'(b_dout), 32'd55);
        b_rd("rdw_new_after", 8'd5, 8'd55);

        // 4. fill, then clear request beats a simultaneous write/read
        for (int i = 0; i < 256; i++) a_wr(8'(i), 8'hAA);
        a_rd("fill_chk", 8'd77, 8'hAA);
        a_addr = 8'd3; a_din = 8'h11; a_we = 1'b1; a_re = 1'b1; a_clr = 1'b1;
        tick();
        a_we = 1'b0; a_re = 1'b0; a_clr = 1'b0;
        chk("clr_dv_drop", 32'(a_dv), 32'd0);
        chk("clr_dout_hold", 32'(a_dout), 32'hAA);
        a_busy_len(n);
        chk("clr_len", 32'(n), 32'd256);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            a_addr = 8'(i); a_re = 1'b1;
            tick();
            a_re = 1'b0;
            if (a_dout !== 8'd0 || a_dv !== 1'b1) bad++;
        end
        chk("clr_all_zero", 32'(bad), 32'd0);

        // 5. reset in the middle of a sweep restarts it
        a_wr(8'd200, 8'h77);
        a_rd("pre5_rd200", 8'd200, 8'h77);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("mid_busy", 32'(a_busy), 32'd1);
        chk("mid_dout_hold", 32'(a_dout), 32'h77);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_dout", 32'(a_dout), 32'd0);
        a_busy_len(n);
        chk("mid_rst_len", 32'(n), 32'd256);
        a_rd("post5_rd200", 8'd200, 8'd0);

        // 6. reduced depth: out-of-range access and top word
        tick();
        chk("c_idle", 32'(c_busy), 32'd0);
        c_wr(8'd250, 8'h5A);
        c_rd("c_oor", 8'd250, 8'h3C);
        c_wr(8'd199, 8'h99);
        c_rd("c_top", 8'd199, 8'h99);
        c_rd("c_clr0", 8'd0, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
